mem_port_arbiter: RTL and testbench

// Shares the single byte-wide port of the unified instruction/data memory between the

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the byte-wide port of the unified instruction/data memory between the
// fetch path and the load/store path. Each grant moves one 32-bit big-endian
// word as four byte beats (MSB first). Data requests normally win; a streak
// counter forces a fetch grant after MAX_DATA_BURST data grants made while a
// fetch was waiting.
//
// Requester handshake: a requester holds *_req high (with stable address,
// we and wdata) until the arbiter grants it. Address, we and wdata are
// latched on the grant edge, so the requester may change them afterwards.
// Completion is a one-cycle *_done pulse. Loads also return the word on
// *_rdata, which holds until that requester's next load completes. The
// cycle after done is always IDLE. A req still high in that cycle is a
// new request, so a requester wanting one transfer drops req on the edge
// that ends its done cycle.
module mem_port_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              mem_Clk,
    input  logic              mem_Rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              fetch_pause,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int STREAK_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
    localparam logic [ADDR_W-1:0]   ADDR_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [2:0]          beat;       // 0..3 bus beats, 4 = load capture-only beat
    logic                owner_d;    // 1 = data path owns the current transfer
    logic                lat_we;     // latched store flag
    logic [23:0]         wsh;        // store bytes still to be driven, next byte on top
    logic [23:0]         cap;        // load bytes captured so far
    logic [STREAK_W-1:0] streak;     // data grants made while fetch was waiting

    logic              fetch_elig;
    logic              fetch_forced;
    logic              grant_d;
    logic              grant_f;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic              unused_addr_hi;

    // Grant decision, only acted on in IDLE
    assign fetch_elig   = if_req & ~fetch_pause;
    assign fetch_forced = fetch_elig & (streak == STREAK_MAX);
    assign grant_d      = d_req & ~fetch_forced;
    assign grant_f      = fetch_elig & ~grant_d;
    assign grant_we     = grant_d & d_we;
    assign grant_addr   = grant_d ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];

    // Upper request address bits are dropped: the port only spans ADDR_W bits
    assign unused_addr_hi = ^{d_addr[31:ADDR_W], if_addr[31:ADDR_W]};

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Arbitration, beat sequencing and registered bus / completion outputs
    always_ff @(posedge mem_Clk or negedge mem_Rst_n) begin
        if (!mem_Rst_n) begin
            state     <= IDLE;
            beat      <= 3'd0;
            owner_d   <= 1'b0;
            lat_we    <= 1'b0;
            wsh       <= '0;
            cap       <= '0;
            streak    <= '0;
            if_done   <= 1'b0;
            if_rdata  <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A waiting fetch only counts against data grants while it is eligible
                    if (!fetch_elig || grant_f) begin
                        streak <= '0;
                    end else if (grant_d && (streak != STREAK_MAX)) begin
                        streak <= streak + STREAK_ONE;
                    end

                    if (grant_d || grant_f) begin
                        state     <= XFER;
                        beat      <= 3'd0;
                        owner_d   <= grant_d;
                        lat_we    <= grant_we;
                        wsh       <= grant_we ? d_wdata[23:0] : 24'h0;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_we;
                        mem_addr  <= grant_addr;
                        mem_wdata <= grant_we ? d_wdata[31:24] : 8'h00;
                    end
                end

                XFER: begin
                    beat <= beat + 3'd1;

                    // Read data lags the address by one cycle: beats 1..3 see bytes 0..2
                    if (!lat_we && (beat != 3'd0) && (beat != 3'd4)) begin
                        cap <= {cap[15:0], mem_rdata};
                    end

                    if (beat < 3'd3) begin
                        // Next byte address wraps naturally at 2^ADDR_W
                        mem_addr  <= mem_addr + ADDR_ONE;
                        mem_wdata <= lat_we ? wsh[23:16] : 8'h00;
                        wsh       <= {wsh[15:0], 8'h00};
                    end else if (beat == 3'd3) begin
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= 8'h00;
                        // Stores finish here; loads still need the last read byte
                        if (lat_we) begin
                            state  <= DONE;
                            d_done <= 1'b1;
                        end
                    end else begin
                        state <= DONE;
                        if (owner_d) begin
                            d_done  <= 1'b1;
                            d_rdata <= {cap, mem_rdata};
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= {cap, mem_rdata};
                        end
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    beat    <= 3'd0;
                    if_done <= 1'b0;
                    d_done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a byte-memory environment, a
// transaction-level reference model and a per-cycle output compare.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W         = 16;
    localparam int MAX_DATA_BURST = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              if_req      = 1'b0;
    logic [31:0]       if_addr     = '0;
    logic              fetch_pause = 1'b0;
    logic              if_done;
    logic [31:0]       if_rdata;
    logic              d_req       = 1'b0;
    logic              d_we        = 1'b0;
    logic [31:0]       d_addr      = '0;
    logic [31:0]       d_wdata     = '0;
    logic              d_done;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata   = 8'h00;
    logic              busy;
    logic [1:0]        dbg_state;

    mem_port_arbiter #(
        .ADDR_W         (ADDR_W),
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) dut (
        .mem_Clk     (clk),
        .mem_Rst_n   (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .fetch_pause (fetch_pause),
        .if_done     (if_done),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_done      (d_done),
        .d_rdata     (d_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [24:0] exp_q[$];     // expected bus beats {we, addr, wdata}
    logic [24:0] bus_q[$];     // observed bus beats
    logic [7:0]  done_q[$];    // observed completions, "D" or "F"
    int busy_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- byte memory environment ----------------
    bit [7:0] env_mem [0:65535];

    // Synchronous-read byte memory; junk on the read bus when not reading
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
        end else if (mem_en) begin
            mem_rdata <= env_mem[mem_addr];
        end else begin
            mem_rdata <= 8'($urandom_range(0, 255));
        end
    end

    // ---------------- reference model ----------------
    // m_t counts cycles since the grant edge (0 = idle, 1 = first beat).
    int          m_t      = 0;
    bit          m_own_d  = 1'b0;
    bit          m_we     = 1'b0;
    logic [15:0] m_base   = '0;
    logic [31:0] m_wdata  = '0;
    int          m_streak = 0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata  = '0;
    bit [7:0]    ref_mem [0:65535];
    wire         m_elig = if_req & ~fetch_pause;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        if (k < 0 || k > 3) return 8'h00;
        return w[31-8*k -: 8];
    endfunction

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        return {ref_mem[a], ref_mem[a + 16'd1], ref_mem[a + 16'd2], ref_mem[a + 16'd3]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t        <= 0;
            m_streak   <= 0;
            m_if_rdata <= '0;
            m_d_rdata  <= '0;
        end else if (m_t == 0) begin
            if (d_req && !(m_elig && m_streak == MAX_DATA_BURST)) begin
                m_t      <= 1;
                m_own_d  <= 1'b1;
                m_we     <= d_we;
                m_base   <= d_addr[15:0];
                m_wdata  <= d_wdata;
                m_streak <= m_elig ? m_streak + 1 : 0;
            end else if (m_elig) begin
                m_t      <= 1;
                m_own_d  <= 1'b0;
                m_we     <= 1'b0;
                m_base   <= if_addr[15:0];
                m_wdata  <= '0;
                m_streak <= 0;
            end else begin
                m_streak <= 0;
            end
        end else begin
            if (m_we && m_t <= 4) begin
                ref_mem[16'(m_base + m_t - 1)] <= byte_of(m_wdata, m_t - 1);
            end
            if (!m_we && m_t == 5) begin
                if (m_own_d) m_d_rdata  <= ref_word(m_base);
                else         m_if_rdata <= ref_word(m_base);
            end
            if ((m_we && m_t == 5) || (!m_we && m_t == 6)) m_t <= 0;
            else                                          m_t <= m_t + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("busy", busy, m_t != 0);
        chk("mem_en", mem_en, m_t >= 1 && m_t <= 4);
        chk("mem_we", mem_we, m_t >= 1 && m_t <= 4 && m_we);
        if (m_t >= 1 && m_t <= 4) chk("mem_addr", mem_addr, 16'(m_base + m_t - 1));
        chk("mem_wdata", mem_wdata, (m_t >= 1 && m_t <= 4 && m_we) ? byte_of(m_wdata, m_t - 1) : 8'h00);
        chk("d_done", d_done, m_own_d && ((m_we && m_t == 5) || (!m_we && m_t == 6)));
        chk("if_done", if_done, !m_own_d && m_t == 6);
        chk("done_excl", if_done & d_done, 0);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        if (mem_en) bus_q.push_back({mem_we, mem_addr, mem_wdata});
        if (d_done)  done_q.push_back(8'h44);
        if (if_done) done_q.push_back(8'h46);
        if (busy) busy_cnt++;
    end

    // ---------------- driver tasks ----------------
    // Waits for the chosen done pulse, then returns #1 after the edge ending the done cycle.
    task automatic wait_done(input bit want_d, input int limit, input string nm, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < limit) begin
            @(negedge clk);
            lat++;
            seen = want_d ? d_done : if_done;
        end
        chk(nm, seen, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input int from, input string nm);
        chk(nm, bus_q.size() - from, exp_q.size());
        foreach (exp_q[i]) begin
            if (from + i < bus_q.size()) chk(nm, bus_q[from + i], exp_q[i]);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int lat;
        int b0;
        int c0;
        int d0;
        int n;
        int k;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: store DEADBEEF at 0x0100
        b0 = bus_q.size();
        c0 = busy_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        wait_done(1'b1, 20, "t1_done_seen", lat);
        d_req = 1'b0; d_we = 1'b0;
        chk("t1_latency", lat, 6);
        chk("t1_busy_cycles", busy_cnt - c0, 5);
        exp_q.delete();
        exp_q.push_back({1'b1, 16'h0100, 8'hDE});
        exp_q.push_back({1'b1, 16'h0101, 8'hAD});
        exp_q.push_back({1'b1, 16'h0102, 8'hBE});
        exp_q.push_back({1'b1, 16'h0103, 8'hEF});
        check_bus(b0, "t1_bus");
        chk("t1_mem", {env_mem[16'h0100], env_mem[16'h0101], env_mem[16'h0102], env_mem[16'h0103]}, 32'hDEAD_BEEF);

        // Test 2: fetch it back
        b0 = bus_q.size();
        if_req = 1'b1; if_addr = 32'h0000_0100;
        wait_done(1'b0, 20, "t2_done_seen", lat);
        if_req = 1'b0;
        chk("t2_latency", lat, 7);
        chk("t2_if_rdata", if_rdata, 32'hDEAD_BEEF);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 16'(16'h0100 + i), 8'h00});
        check_bus(b0, "t2_bus");

        // Test 3a: simultaneous requests, data first, fetch right after
        d0 = done_q.size();
        if_req = 1'b1; if_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
        wait_done(1'b1, 20, "t3_d_seen", lat);
        d_req = 1'b0;
        chk("t3_d_latency", lat, 7);
        chk("t3_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("t3_first_is_data", done_q[d0], 8'h44);
        wait_done(1'b0, 20, "t3_f_seen", lat);
        if_req = 1'b0;
        chk("t3_f_latency", lat, 7);

        // Test 3b: same, but fetch paused until released
        fetch_pause = 1'b1;
        if_req = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
        wait_done(1'b1, 20, "t3b_d_seen", lat);
        d_req = 1'b0;
        d0 = done_q.size();
        repeat (8) @(posedge clk);
        #1;
        chk("t3b_no_fetch", done_q.size() - d0, 0);
        chk("t3b_idle", busy, 1'b0);
        fetch_pause = 1'b0;
        wait_done(1'b0, 20, "t3b_f_seen", lat);
        if_req = 1'b0;
        chk("t3b_f_latency", lat, 7);

        // Test 4: back-to-back loads with fetch waiting; 5th grant is fetch
        if_req = 1'b1; if_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
        n = 0;
        k = 0;
        while (n < 6 && k < 120) begin
            @(negedge clk);
            k++;
            if (if_done || d_done) begin
                chk("t4_order_is_fetch", if_done, n == 4);
                n++;
            end
        end
        chk("t4_six_grants", n, 6);
        @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;

        // Test 5: store across the address wrap
        b0 = bus_q.size();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h00AB_FFFE; d_wdata = 32'h1122_3344;
        wait_done(1'b1, 20, "t5_done_seen", lat);
        d_req = 1'b0; d_we = 1'b0;
        exp_q.delete();
        exp_q.push_back({1'b1, 16'hFFFE, 8'h11});
        exp_q.push_back({1'b1, 16'hFFFF, 8'h22});
        exp_q.push_back({1'b1, 16'h0000, 8'h33});
        exp_q.push_back({1'b1, 16'h0001, 8'h44});
        check_bus(b0, "t5_bus");
        if_req = 1'b1; if_addr = 32'h0001_FFFE;
        wait_done(1'b0, 20, "t5_f_seen", lat);
        if_req = 1'b0;
        chk("t5_if_rdata", if_rdata, 32'h1122_3344);

        // Test 6: reset during beat 2 of a store, then fresh grant
        d0 = done_q.size();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_beat2_addr", mem_addr, 16'h0302);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mem_en", mem_en, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_d_done", d_done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_no_done", done_q.size() - d0, 0);
        chk("t6_partial", {env_mem[16'h0300], env_mem[16'h0301], env_mem[16'h0302]}, 24'hCAFE00);
        b0 = bus_q.size();
        rst_n = 1'b1;
        wait_done(1'b1, 20, "t6_done_seen", lat);
        d_req = 1'b0; d_we = 1'b0;
        chk("t6_latency", lat, 6);
        exp_q.delete();
        exp_q.push_back({1'b1, 16'h0300, 8'hCA});
        exp_q.push_back({1'b1, 16'h0301, 8'hFE});
        exp_q.push_back({1'b1, 16'h0302, 8'hF0});
        exp_q.push_back({1'b1, 16'h0303, 8'h0D});
        check_bus(b0, "t6_bus");
        chk("t6_mem", {env_mem[16'h0300], env_mem[16'h0301], env_mem[16'h0302], env_mem[16'h0303]}, 32'hCAFE_F00D);

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
